// File: rtl/vga_tile_scanner.sv
// VGA 640x480@60 scanner that walks a 16x12 grid of 40x40-pixel tiles.
// A 25 MHz pixel tick is derived from the 50 MHz Clock. Tile coordinates
// come from counters only, so no divider or multiplier is built. The
// colour, sync and blank outputs share a two-tick pipeline: address, then
// RAM data, then the pins.
module vga_tile_scanner #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int TILE_PIX   = 40,
  parameter int TILES_H    = 16,
  parameter int TILES_V    = 12,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  input  logic [2:0]            iReadData,
  output logic                  RED,
  output logic                  GREEN,
  output logic                  BLUE,
  output logic                  HS,
  output logic                  VS,
  output logic                  oBlank,
  output logic                  oFrameStart
);

  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW         = $clog2(H_TOTAL);
  localparam int VW         = $clog2(V_TOTAL);
  localparam int TSW        = $clog2(TILE_PIX);
  localparam int TCW        = $clog2((H_TOTAL - 1) / TILE_PIX + 1);
  localparam int TRW        = $clog2((V_TOTAL - 1) / TILE_PIX + 1);
  localparam int TILE_SHIFT = $clog2(TILES_H);

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0]  HS_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0]  HS_STOP  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0]  VS_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0]  VS_STOP  = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [TSW-1:0] T_LAST   = TSW'(TILE_PIX - 1);
  localparam logic [TCW-1:0] TC_LIMIT = TCW'(TILES_H);
  localparam logic [TRW-1:0] TR_LIMIT = TRW'(TILES_V);

  logic                  phase;
  logic                  tick;
  logic [HW-1:0]         h_count;
  logic [VW-1:0]         v_count;
  logic [TSW-1:0]        col_sub;
  logic [TSW-1:0]        row_sub;
  logic [TCW-1:0]        tile_col;
  logic [TRW-1:0]        tile_row;
  logic                  line_end;
  logic                  visible;
  logic                  hs_raw;
  logic                  vs_raw;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  hs_d1;
  logic                  vs_d1;
  logic                  blank_d1;

  // Pixel tick divider: the tick lands on the second Clock edge after reset
  // releases, and on every second edge after that.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) phase <= 1'b0;
    else       phase <= ~phase;
  end

  assign tick     = phase;
  assign line_end = (h_count == H_LAST);

  // Raster position counters.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (tick) begin
      if (line_end) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  // Tile column counter. It clears on the last pixel of the line, so both
  // the subcounter and tile_col read 0 while h_count is 0.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col_sub  <= '0;
      tile_col <= '0;
    end else if (tick) begin
      if (line_end) begin
        col_sub  <= '0;
        tile_col <= '0;
      end else if (col_sub == T_LAST) begin
        col_sub  <= '0;
        tile_col <= tile_col + 1'b1;
      end else begin
        col_sub  <= col_sub + 1'b1;
      end
    end
  end

  // Tile row counter. It advances once per line and clears on the frame's
  // last line, so it reads 0 while v_count is 0.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      row_sub  <= '0;
      tile_row <= '0;
    end else if (tick && line_end) begin
      if (v_count == V_LAST) begin
        row_sub  <= '0;
        tile_row <= '0;
      end else if (row_sub == T_LAST) begin
        row_sub  <= '0;
        tile_row <= tile_row + 1'b1;
      end else begin
        row_sub  <= row_sub + 1'b1;
      end
    end
  end

  // Visibility, raw sync levels and the shift-and-add tile address.
  // The tile-limit terms keep the address inside the grid even if a
  // parameter set does not divide evenly.
  always_comb begin
    visible   = (h_count < H_VIS) && (v_count < V_VIS) &&
                (tile_col < TC_LIMIT) && (tile_row < TR_LIMIT);
    hs_raw    = !((h_count >= HS_START) && (h_count < HS_STOP));
    vs_raw    = !((v_count >= VS_START) && (v_count < VS_STOP));
    addr_next = '0;
    if (visible)
      addr_next = (ADDR_WIDTH'(tile_row) << TILE_SHIFT) + ADDR_WIDTH'(tile_col);
  end

  // Two-tick output pipeline: stage 1 registers the address with the
  // matching sync/blank; stage 2 captures the RAM data with them.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oReadAddress        <= '0;
      hs_d1               <= 1'b1;
      vs_d1               <= 1'b1;
      blank_d1            <= 1'b1;
      HS                  <= 1'b1;
      VS                  <= 1'b1;
      oBlank              <= 1'b1;
      {RED, GREEN, BLUE}  <= '0;
    end else if (tick) begin
      oReadAddress        <= addr_next;
      hs_d1               <= hs_raw;
      vs_d1               <= vs_raw;
      blank_d1            <= ~visible;
      HS                  <= hs_d1;
      VS                  <= vs_d1;
      oBlank              <= blank_d1;
      {RED, GREEN, BLUE}  <= blank_d1 ? 3'b000 : iReadData;
    end
  end

  // Frame start is high for the one Clock whose tick processes pixel (0,0).
  always_comb begin
    oFrameStart = tick && (h_count == '0) && (v_count == '0);
  end

endmodule
